// File: rtl/cpu_io_agent_pkg.sv
// Shared constants and the input-path state type for the CPU I/O agent.
// The optional CPU_IO_AGENT_OVF_CNT_EN feature (dropped-word counter) is configured in the top module.
package cpu_io_agent_pkg;

    localparam int DATA_W        = 16;
    localparam int DEFAULT_DEPTH = 4;
    localparam int OVF_W         = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } in_state_e;

endpackage

// File: rtl/cpu_io_fifo.sv
// Output-path FIFO: DEPTH words, power-of-two pointers wrapping naturally.
// Head word is presented combinationally and forced to zero while empty.
module cpu_io_fifo
    import cpu_io_agent_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int W     = DATA_W,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  pop_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    // A push while full is only legal when a pop frees the head slot this edge.
    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_comb begin
        full     = (count_q == CW'(DEPTH));
        empty    = (count_q == '0);
        count    = count_q;
        pop_data = empty ? '0 : mem_q[rd_ptr_q];
    end

endmodule

// File: rtl/cpu_io_agent.sv
// CPU I/O agent: buffered CPU->host output FIFO and single-word host->CPU input holding register.
// Define CPU_IO_AGENT_OVF_CNT_EN to add the saturating ovf_count dropped-word counter.
module cpu_io_agent
    import cpu_io_agent_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] cpu_out_data,
    input  logic              cpu_out_wr,
    output logic [DATA_W-1:0] cpu_in_data,
    input  logic              cpu_in_rd,
    output logic              in_pending,
    output logic [DATA_W-1:0] host_tx_data,
    output logic              host_tx_valid,
    input  logic              host_tx_ready,
    input  logic [DATA_W-1:0] host_rx_data,
    input  logic              host_rx_valid,
    output logic              host_rx_ready
`ifdef CPU_IO_AGENT_OVF_CNT_EN
    ,
    output logic [OVF_W-1:0]  ovf_count
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;

    in_state_e         state_q, state_d;
    logic [DATA_W-1:0] in_data_q, in_data_d;

    // A write into a full FIFO is dropped unless the host drains the head this same edge.
    always_comb begin
        host_tx_valid = !fifo_empty;
        fifo_pop      = host_tx_valid && host_tx_ready;
        fifo_push     = cpu_out_wr && (!fifo_full || fifo_pop);
        assert (fifo_empty == (fifo_count == '0));
    end

    cpu_io_fifo #(
        .DEPTH (DEPTH),
        .W     (DATA_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (cpu_out_data),
        .pop       (fifo_pop),
        .pop_data  (host_tx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= EMPTY;
            in_data_q <= '0;
        end else begin
            state_q   <= state_d;
            in_data_q <= in_data_d;
        end
    end

    // Leaving FULL only reopens host_rx_ready on the next cycle, so no same-cycle refill.
    always_comb begin
        state_d   = state_q;
        in_data_d = in_data_q;
        case (state_q)
            EMPTY: begin
                if (host_rx_valid) begin
                    state_d   = FULL;
                    in_data_d = host_rx_data;
                end
            end
            FULL: begin
                if (cpu_in_rd) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        host_rx_ready = (state_q == EMPTY);
        in_pending    = (state_q == FULL);
        cpu_in_data   = in_data_q;
    end

`ifdef CPU_IO_AGENT_OVF_CNT_EN
    logic [OVF_W-1:0] ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (cpu_out_wr && !fifo_push && (ovf_q != '1)) begin
            ovf_d = ovf_q + OVF_W'(1);
        end
        ovf_count = ovf_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_io_agent.sv
// Scoreboard bench for cpu_io_agent: directed stimulus queues expected host words, a negedge monitor checks them.
// Define CPU_IO_AGENT_OVF_CNT_EN for both RTL and bench to exercise ovf_count.
module tb_cpu_io_agent;

   logic        clock = 1'b0;
   logic        reset;
   logic [15:0] cpu_out_data;
   logic        cpu_out_wr;
   logic [15:0] cpu_in_data;
   logic        cpu_in_rd;
   logic        in_pending;
   logic [15:0] host_tx_data;
   logic        host_tx_valid;
   logic        host_tx_ready;
   logic [15:0] host_rx_data;
   logic        host_rx_valid;
   logic        host_rx_ready;
`ifdef CPU_IO_AGENT_OVF_CNT_EN
   logic [7:0]  ovf_count;
`endif

   logic [15:0] expQ [$];
   int          checkCount = 0;
   int          failCount  = 0;

   cpu_io_agent #(.DEPTH(4)) dut (
      .clock         (clock),
      .reset         (reset),
      .cpu_out_data  (cpu_out_data),
      .cpu_out_wr    (cpu_out_wr),
      .cpu_in_data   (cpu_in_data),
      .cpu_in_rd     (cpu_in_rd),
      .in_pending    (in_pending),
      .host_tx_data  (host_tx_data),
      .host_tx_valid (host_tx_valid),
      .host_tx_ready (host_tx_ready),
      .host_rx_data  (host_rx_data),
      .host_rx_valid (host_rx_valid),
      .host_rx_ready (host_rx_ready)
`ifdef CPU_IO_AGENT_OVF_CNT_EN
      ,
      .ovf_count     (ovf_count)
`endif
   );

   always #5 clock = ~clock;

   // One comparison: count it, and report any difference.
   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%04h, required 0x%04h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Drive every input for one cycle, then advance past the next rising edge.
   task automatic applyStimulus(input logic wr, input logic [15:0] wdata, input logic txReady,
                                input logic rxValid, input logic [15:0] rxData, input logic rd);
      cpu_out_wr    = wr;
      cpu_out_data  = wdata;
      host_tx_ready = txReady;
      host_rx_valid = rxValid;
      host_rx_data  = rxData;
      cpu_in_rd     = rd;
      tick();
   endtask

   task automatic expectWord(input logic [15:0] w);
      expQ.push_back(w);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_tx_valid"}, 16'(host_tx_valid), 16'h0000);
      checkOutput({tag, "_tx_data"}, host_tx_data, 16'h0000);
      checkOutput({tag, "_cpu_in_data"}, cpu_in_data, 16'h0000);
      checkOutput({tag, "_in_pending"}, 16'(in_pending), 16'h0000);
      checkOutput({tag, "_rx_ready"}, 16'(host_rx_ready), 16'h0001);
`ifdef CPU_IO_AGENT_OVF_CNT_EN
      checkOutput({tag, "_ovf_count"}, 16'(ovf_count), 16'h0000);
`endif
   endtask

   // Monitor: every presented head word must match the scoreboard front, popped on handshake.
   always @(negedge clock) begin
      if (!reset && host_tx_valid) begin
         if (expQ.size() == 0) begin
            checkOutput("tx_unexpected_word", 16'(host_tx_valid), 16'h0000);
         end else begin
            checkOutput(host_tx_ready ? "tx_word_pop" : "tx_word_hold", host_tx_data, expQ[0]);
            if (host_tx_ready) begin
               void'(expQ.pop_front());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset         = 1'b1;
      cpu_out_wr    = 1'b0;
      cpu_out_data  = '0;
      cpu_in_rd     = 1'b0;
      host_tx_ready = 1'b0;
      host_rx_valid = 1'b0;
      host_rx_data  = '0;
      repeat (3) @(posedge clock);
      #1;
      checkResetValues("por");
      reset = 1'b0;

      // Two words streamed straight through with the host always ready.
      expectWord(16'h1234);
      applyStimulus(1'b1, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b0);
      checkOutput("tx_latency_valid", 16'(host_tx_valid), 16'h0001);
      expectWord(16'h5678);
      applyStimulus(1'b1, 16'h5678, 1'b1, 1'b0, 16'h0000, 1'b0);
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0);
      checkOutput("tx_valid_drop", 16'(host_tx_valid), 16'h0000);

      // Six writes against a stalled host: the last two are dropped.
      for (int i = 1; i <= 6; i++) begin
         if (i <= 4) expectWord(16'(i));
         applyStimulus(1'b1, 16'(i), 1'b0, 1'b0, 16'h0000, 1'b0);
      end
      checkOutput("stall_head", host_tx_data, 16'h0001);
`ifdef CPU_IO_AGENT_OVF_CNT_EN
      checkOutput("ovf_after_two_drops", 16'(ovf_count), 16'h0002);
`endif
      repeat (5) applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0);
      checkOutput("drain_valid", 16'(host_tx_valid), 16'h0000);
      checkOutput("drain_sb_empty", 16'(expQ.size()), 16'h0000);

      // Full FIFO with simultaneous push and pop, then a push that must drop.
      expectWord(16'h0011);
      applyStimulus(1'b1, 16'h0011, 1'b0, 1'b0, 16'h0000, 1'b0);
      expectWord(16'h0022);
      applyStimulus(1'b1, 16'h0022, 1'b0, 1'b0, 16'h0000, 1'b0);
      expectWord(16'h0033);
      applyStimulus(1'b1, 16'h0033, 1'b0, 1'b0, 16'h0000, 1'b0);
      expectWord(16'h0044);
      applyStimulus(1'b1, 16'h0044, 1'b0, 1'b0, 16'h0000, 1'b0);
      expectWord(16'h00AA);
      applyStimulus(1'b1, 16'h00AA, 1'b1, 1'b0, 16'h0000, 1'b0);
      applyStimulus(1'b1, 16'h0055, 1'b0, 1'b0, 16'h0000, 1'b0);
`ifdef CPU_IO_AGENT_OVF_CNT_EN
      checkOutput("ovf_after_full_drop", 16'(ovf_count), 16'h0003);
`endif
      repeat (6) applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0);
      checkOutput("pushpop_drain_valid", 16'(host_tx_valid), 16'h0000);
      checkOutput("pushpop_sb_empty", 16'(expQ.size()), 16'h0000);

      // Input path: load, hold off a second word, read, refill one cycle later.
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 1'b0);
      checkOutput("rx_pending", 16'(in_pending), 16'h0001);
      checkOutput("rx_data", cpu_in_data, 16'hBEEF);
      checkOutput("rx_ready_low", 16'(host_rx_ready), 16'h0000);
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 16'hCAFE, 1'b0);
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 16'hCAFE, 1'b0);
      checkOutput("rx_held_off", cpu_in_data, 16'hBEEF);
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 16'hCAFE, 1'b1);
      checkOutput("rd_ready_back", 16'(host_rx_ready), 16'h0001);
      checkOutput("rd_not_pending", 16'(in_pending), 16'h0000);
      checkOutput("rd_no_refill", cpu_in_data, 16'hBEEF);
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 16'hCAFE, 1'b0);
      checkOutput("refill_pending", 16'(in_pending), 16'h0001);
      checkOutput("refill_data", cpu_in_data, 16'hCAFE);
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);
      checkOutput("rd_empty_ignored", 16'(in_pending), 16'h0000);
      checkOutput("rd_empty_keeps_data", cpu_in_data, 16'hCAFE);

      // Simultaneous output push and input load, then queue up for a mid-operation reset.
      expectWord(16'h0F0F);
      applyStimulus(1'b1, 16'h0F0F, 1'b0, 1'b1, 16'h1357, 1'b0);
      checkOutput("both_tx_valid", 16'(host_tx_valid), 16'h0001);
      checkOutput("both_rx_data", cpu_in_data, 16'h1357);
      expectWord(16'h0A0A);
      applyStimulus(1'b1, 16'h0A0A, 1'b0, 1'b0, 16'h0000, 1'b0);
      expectWord(16'h0B0B);
      applyStimulus(1'b1, 16'h0B0B, 1'b0, 1'b0, 16'h0000, 1'b0);
      @(posedge clock);
      #3;
      reset = 1'b1;
      expQ.delete();
      #1;
      checkResetValues("midrst");
      @(posedge clock);
      #1;
      reset = 1'b0;
      expectWord(16'h7777);
      applyStimulus(1'b1, 16'h7777, 1'b0, 1'b1, 16'h2468, 1'b0);
      checkOutput("postrst_tx_valid", 16'(host_tx_valid), 16'h0001);
      checkOutput("postrst_rx_data", cpu_in_data, 16'h2468);
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0);
      checkOutput("postrst_drained", 16'(host_tx_valid), 16'h0000);
      checkOutput("postrst_pending", 16'(in_pending), 16'h0000);
      checkOutput("postrst_sb_empty", 16'(expQ.size()), 16'h0000);

`ifdef CPU_IO_AGENT_OVF_CNT_EN
      // Saturation of the dropped-word counter.
      for (int i = 0; i < 4; i++) begin
         expectWord(16'hC000 + 16'(i));
         applyStimulus(1'b1, 16'hC000 + 16'(i), 1'b0, 1'b0, 16'h0000, 1'b0);
      end
      repeat (254) applyStimulus(1'b1, 16'hDEAD, 1'b0, 1'b0, 16'h0000, 1'b0);
      checkOutput("ovf_254", 16'(ovf_count), 16'h00FE);
      repeat (46) applyStimulus(1'b1, 16'hDEAD, 1'b0, 1'b0, 16'h0000, 1'b0);
      checkOutput("ovf_sat_300", 16'(ovf_count), 16'h00FF);
      repeat (5) applyStimulus(1'b1, 16'hDEAD, 1'b0, 1'b0, 16'h0000, 1'b0);
      checkOutput("ovf_sat_hold", 16'(ovf_count), 16'h00FF);
      repeat (6) applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0);
      checkOutput("sat_sb_empty", 16'(expQ.size()), 16'h0000);
`endif

      repeat (2) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule

// File: doc/cpu_io_agent.md
CPU_IO_AGENT -- requirements
Module: cpu_io_agent

Interface
REQ-001 SHALL have parameter DEPTH, default 4: output FIFO depth in words (power of two, 2..16).
REQ-002 SHALL have port clock  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port cpu_out_data  input  16  word written by the CPU output instruction.
REQ-005 SHALL have port cpu_out_wr  input  1  one-cycle strobe per CPU output write.
REQ-006 SHALL have port cpu_in_data  output  16  word presented to the CPU input bus.
REQ-007 SHALL have port cpu_in_rd  input  1  one-cycle strobe when the CPU consumes cpu_in_data.
REQ-008 SHALL have port in_pending  output  1  high while an unread input word is held.
REQ-009 SHALL have port host_tx_data  output  16  head-of-FIFO word toward the host.
REQ-010 SHALL have port host_tx_valid  output  1  host_tx_data is valid.
REQ-011 SHALL have port host_tx_ready  input  1  host accepts host_tx_data.
REQ-012 SHALL have port host_rx_data  input  16  word from host for the CPU.
REQ-013 SHALL have port host_rx_valid  input  1  host_rx_data is valid.
REQ-014 SHALL have port host_rx_ready  output  1  agent can accept a host word.
REQ-015 SHALL have port ovf_count  output  8  dropped-output-word count (present only with the REQ-032 macro).

Function
REQ-016 Output path: DEPTH-entry FIFO; cpu_out_wr while not full SHALL push cpu_out_data.
REQ-017 cpu_out_wr while full with no same-cycle pop SHALL drop the word; FIFO contents unchanged.
REQ-018 Push and pop in the same cycle while full SHALL accept the push; occupancy unchanged.
REQ-019 Push into an empty FIFO SHALL raise host_tx_valid the following cycle (1-cycle latency), carrying that word.
REQ-020 Pop occurs exactly when host_tx_valid && host_tx_ready at a clock edge; words leave in push order.
REQ-021 host_tx_data SHALL remain stable while host_tx_valid && !host_tx_ready.
REQ-022 Pointers SHALL wrap modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits wide; full = occupancy==DEPTH.
REQ-023 Input path: two-state FSM, EMPTY and FULL; host_rx_ready = (state==EMPTY), registered.
REQ-024 EMPTY with host_rx_valid SHALL load host_rx_data into cpu_in_data and move to FULL next edge.
REQ-025 FULL with cpu_in_rd SHALL move to EMPTY; host_rx_ready rises the following cycle (no same-cycle refill).
REQ-026 cpu_in_rd while EMPTY SHALL be ignored; cpu_in_data keeps its last value in EMPTY.
REQ-027 in_pending = (state==FULL).
REQ-028 Input and output paths SHALL operate independently; simultaneous events on both take effect in the same cycle.

Reset
REQ-029 reset SHALL force: host_tx_valid=0, host_tx_data=0, cpu_in_data=0, in_pending=0, host_rx_ready=1, FSM=EMPTY, pointers and occupancy=0, ovf_count=0.
REQ-030 reset mid-operation SHALL discard all FIFO contents and any held input word; no partial transfer completes.
REQ-031 After reset deasserts, first push or load SHALL be accepted on the next rising edge.

Configuration
REQ-032 Macro CPU_IO_AGENT_OVF_CNT_EN defined: ovf_count port exists, increments by 1 per dropped word (REQ-017), saturates at 255.
REQ-033 Macro undefined: no ovf_count port and no counter logic; drop behaviour otherwise identical.

Structure
REQ-034 Shared package SHALL hold the data width constant (16), default DEPTH, and the input FSM state enum (EMPTY, FULL).
REQ-035 Output FIFO SHALL be one sub-module, cpu_io_fifo (push/pop/full/empty/count), instantiated once.

Verification
REQ-036 Reset, push 0x1234, 0x5678 with host_tx_ready=1 -> host_tx_data 0x1234 then 0x5678 on consecutive cycles, valid drops after.
REQ-037 host_tx_ready=0, 6 pushes 0x0001..0x0006 (DEPTH=4) -> 0x0001..0x0004 drained in order; ovf_count=2 with macro.
REQ-038 Full FIFO, push 0x00AA with same-cycle pop -> push accepted, occupancy stays 4, 0x00AA exits last.
REQ-039 host_rx 0xBEEF -> in_pending=1, cpu_in_data=0xBEEF, host_rx_ready=0; second host word held off until cycle after cpu_in_rd.
REQ-040 Reset asserted with 3 queued words and FULL input -> all outputs at REQ-029 values; no queued word appears afterward.
REQ-041 ovf_count reaches 255 after 300 drops and holds at 255.
